tag_lookup_ctrl: RTL and testbench

- Single-clock lookup/allocate controller for the 64x8 tag SDPRAM (drm_tag). It drives both RAM ports, with wr_clk and rd_clk tied to clk and OUTPUT_REG=0.
- Each tag word is {valid, tag[TAG_WIDTH-1:0]}.
- Clears every entry after reset, serves lookup requests (compare, optional allocate on miss) and invalidate requests.
- Sits between the cache request pipeline and the tag RAM.

---
 rtl/tag_lookup_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Lookup/allocate controller for the drm_tag 64x8 SDPRAM.
// Optional hit/miss statistics: define TAG_LOOKUP_CTRL_STATS_EN.
module tag_lookup_ctrl #(
  parameter int IDX_WIDTH = 6,
  parameter int TAG_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_WIDTH-1:0] req_idx,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_alloc,
  input  logic                 inv_valid,
  output logic                 inv_ready,
  input  logic [IDX_WIDTH-1:0] inv_idx,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [IDX_WIDTH-1:0] rsp_idx,
  output logic [TAG_WIDTH:0]   rsp_old_tag,
  output logic                 init_done,
  output logic                 ram_wr_en,
  output logic [IDX_WIDTH-1:0] ram_wr_addr,
  output logic [TAG_WIDTH:0]   ram_wr_data,
  output logic                 ram_wr_byte_en,
  output logic [IDX_WIDTH-1:0] ram_rd_addr,
  input  logic [TAG_WIDTH:0]   ram_rd_data,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_CMP
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  state_t state_q, state_d;

  logic [IDX_WIDTH-1:0] sweep_q, sweep_d;
  logic                 init_done_q, init_done_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 alloc_q, alloc_d;
  logic [IDX_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [IDX_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [TAG_WIDTH:0]   wr_data_q, wr_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [IDX_WIDTH-1:0] rsp_idx_q, rsp_idx_d;
  logic [TAG_WIDTH:0]   rsp_old_q, rsp_old_d;
  logic                 hit;

  // Stored entry matches when valid and tag bits agree.
  assign hit = ram_rd_data[TAG_WIDTH] &&
               (ram_rd_data[TAG_WIDTH-1:0] == tag_q);

  assign req_ready      = (state_q == S_IDLE) && !inv_valid;
  assign inv_ready      = (state_q == S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_hit        = rsp_hit_q;
  assign rsp_idx        = rsp_idx_q;
  assign rsp_old_tag    = rsp_old_q;
  assign init_done      = init_done_q;
  assign ram_wr_en      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_wr_byte_en = 1'b1;
  assign ram_rd_addr    = rd_addr_q;

  // Next-state and registered-output logic for the sweep/lookup FSM.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    alloc_d     = alloc_q;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_old_d   = rsp_old_q;
    unique case (state_q)
      S_INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = sweep_q;
        wr_data_d = '0;
        sweep_d   = sweep_q + IDX_WIDTH'(1);
        if (sweep_q == LAST_IDX) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (inv_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = inv_idx;
          wr_data_d = '0;
        end else if (req_valid) begin
          idx_d     = req_idx;
          tag_d     = req_tag;
          alloc_d   = req_alloc;
          rd_addr_d = req_idx;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        rsp_valid_d = 1'b1;
        rsp_hit_d   = hit;
        rsp_idx_d   = idx_q;
        rsp_old_d   = ram_rd_data;
        if (!hit && alloc_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {1'b1, tag_q};
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and output registers; reset restarts the clear sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
      tag_q       <= '0;
      alloc_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_old_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      alloc_q     <= alloc_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_old_q   <= rsp_old_d;
    end
  end

`ifdef TAG_LOOKUP_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counts, bumped once per response pulse.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rsp_valid_q) begin
      if (rsp_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed self-checking bench for tag_lookup_ctrl.
// Includes a behavioural model of the tag SDPRAM.
module tb_tag_lookup_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_alloc;
  logic [5:0] req_idx;
  logic [6:0] req_tag;
  logic       inv_valid, inv_ready;
  logic [5:0] inv_idx;
  logic       rsp_valid, rsp_hit;
  logic [5:0] rsp_idx;
  logic [7:0] rsp_old_tag;
  logic       init_done;
  logic       ram_wr_en, ram_wr_byte_en;
  logic [5:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic [15:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  logic       fill;
  logic [7:0] mem [64];

  int         l_lat, l_nwr;
  logic       l_hit, l_rdy;
  logic [7:0] l_old, l_wd;
  logic [5:0] l_idx, l_wa;

  always #5 clk = ~clk;

  tag_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_tag(req_tag),
    .req_alloc(req_alloc),
    .inv_valid(inv_valid), .inv_ready(inv_ready),
    .inv_idx(inv_idx),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .rsp_old_tag(rsp_old_tag),
    .init_done(init_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_wr_byte_en(ram_wr_byte_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Tag RAM model: synchronous write, synchronous read, no output reg.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hA5;
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Starts at a negedge; returns at the negedge showing the response.
  task automatic lookup(input logic [5:0] idx, input logic [6:0] tag,
                        input logic alloc);
    req_valid = 1'b1;
    req_idx   = idx;
    req_tag   = tag;
    req_alloc = alloc;
    #1 l_rdy = req_ready;
    l_lat = 0; l_nwr = 0; l_hit = 1'b0;
    l_old = '0; l_idx = '0; l_wa = '0; l_wd = '0;
    for (int c = 1; c <= 8 && l_lat == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ram_wr_en) begin
        l_nwr++;
        l_wa = ram_wr_addr;
        l_wd = ram_wr_data;
      end
      if (rsp_valid) begin
        l_lat = c;
        l_hit = rsp_hit;
        l_old = rsp_old_tag;
        l_idx = rsp_idx;
      end
    end
  endtask

  // Counts cycles of the clear sweep that deviate from addr 0..63, data 0.
  task automatic sweep_check(output int bad, output int bad_rdy,
                             output int bad_rsp);
    bad = 0; bad_rdy = 0; bad_rsp = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== 6'(i) ||
          ram_wr_data !== 8'h00) bad++;
      if (i < 63 && (init_done !== 1'b0 || req_ready !== 1'b0 ||
                     inv_ready !== 1'b0)) bad_rdy++;
      if (rsp_valid !== 1'b0) bad_rsp++;
    end
  endtask

  task automatic test_reset;
    int bad, bad_rdy, bad_rsp, nz;
    rst = 1'b1; fill = 1'b1;
    req_valid = 0; req_alloc = 0; req_idx = 0; req_tag = 0;
    inv_valid = 0; inv_idx = 0;
    repeat (2) @(negedge clk);
    fill = 1'b0;
    checks++;
    if ({init_done, req_ready, inv_ready, rsp_valid, ram_wr_en} !== 5'b0)
      begin errors++; $display("FAIL reset_ctl got %b want 00000",
        {init_done, req_ready, inv_ready, rsp_valid, ram_wr_en}); end
    checks++;
    if ({ram_rd_addr, ram_wr_addr, ram_wr_data, rsp_old_tag} !== 28'h0)
      begin errors++; $display("FAIL reset_data got %h want 0",
        {ram_rd_addr, ram_wr_addr, ram_wr_data, rsp_old_tag}); end
    checks++;
    if (ram_wr_byte_en !== 1'b1) begin errors++;
      $display("FAIL byte_en got %b want 1", ram_wr_byte_en); end
    rst = 1'b0;
    sweep_check(bad, bad_rdy, bad_rsp);
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL sweep bad_cycles got %0d want 0", bad); end
    checks++;
    if (bad_rdy != 0) begin errors++;
      $display("FAIL sweep_ready bad_cycles got %0d want 0", bad_rdy); end
    checks++;
    if (init_done !== 1'b1) begin errors++;
      $display("FAIL init_done_last got %b want 1", init_done); end
    @(negedge clk);
    checks++;
    if ({ram_wr_en, init_done, req_ready, inv_ready} !== 4'b0111) begin
      errors++; $display("FAIL post_init got %b want 0111",
        {ram_wr_en, init_done, req_ready, inv_ready}); end
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'h00) nz++;
    checks++;
    if (nz != 0) begin errors++;
      $display("FAIL ram_cleared nonzero got %0d want 0", nz); end
  endtask

  task automatic test_miss_no_alloc;
    lookup(6'd5, 7'h12, 1'b0);
    checks++;
    if (l_rdy !== 1'b1) begin errors++;
      $display("FAIL nalloc_ready got %b want 1", l_rdy); end
    checks++;
    if (l_lat != 3) begin errors++;
      $display("FAIL nalloc_latency got %0d want 3", l_lat); end
    checks++;
    if ({l_hit, l_old, l_idx} !== {1'b0, 8'h00, 6'd5}) begin errors++;
      $display("FAIL nalloc_rsp got %b/%h/%0d want 0/00/5",
        l_hit, l_old, l_idx); end
    checks++;
    if (l_nwr != 0) begin errors++;
      $display("FAIL nalloc_write got %0d want 0", l_nwr); end
    @(negedge clk);
    checks++;
    if ({rsp_valid, ram_wr_en} !== 2'b00) begin errors++;
      $display("FAIL rsp_pulse got %b want 00", {rsp_valid, ram_wr_en}); end
  endtask

  task automatic test_alloc_then_hit;
    lookup(6'd5, 7'h12, 1'b1);
    checks++;
    if ({l_hit, l_old} !== {1'b0, 8'h00} || l_lat != 3) begin errors++;
      $display("FAIL alloc_miss got %b/%h lat %0d want 0/00 lat 3",
        l_hit, l_old, l_lat); end
    checks++;
    if (l_nwr != 1 || l_wa !== 6'd5 || l_wd !== 8'h92) begin errors++;
      $display("FAIL alloc_write got n%0d @%0d %h want n1 @5 92",
        l_nwr, l_wa, l_wd); end
    lookup(6'd5, 7'h12, 1'b1);
    checks++;
    if (l_lat != 3 || l_rdy !== 1'b1) begin errors++;
      $display("FAIL b2b_lat got %0d rdy %b want 3 rdy 1", l_lat, l_rdy); end
    checks++;
    if ({l_hit, l_old} !== {1'b1, 8'h92} || l_nwr != 0) begin errors++;
      $display("FAIL alloc_hit got %b/%h n%0d want 1/92 n0",
        l_hit, l_old, l_nwr); end
  endtask

  task automatic test_replace;
    lookup(6'd5, 7'h13, 1'b1);
    checks++;
    if ({l_hit, l_old} !== {1'b0, 8'h92}) begin errors++;
      $display("FAIL repl_rsp got %b/%h want 0/92", l_hit, l_old); end
    checks++;
    if (l_nwr != 1 || l_wa !== 6'd5 || l_wd !== 8'h93) begin errors++;
      $display("FAIL repl_write got n%0d @%0d %h want n1 @5 93",
        l_nwr, l_wa, l_wd); end
    lookup(6'd63, 7'h7F, 1'b1);
    checks++;
    if (l_hit !== 1'b0 || l_wa !== 6'd63 || l_wd !== 8'hFF) begin errors++;
      $display("FAIL idx63_alloc got %b @%0d %h want 0 @63 FF",
        l_hit, l_wa, l_wd); end
    lookup(6'd63, 7'h7F, 1'b0);
    checks++;
    if ({l_hit, l_old, l_idx} !== {1'b1, 8'hFF, 6'd63}) begin errors++;
      $display("FAIL idx63_hit got %b/%h/%0d want 1/FF/63",
        l_hit, l_old, l_idx); end
    lookup(6'd9, 7'h13, 1'b0);
    checks++;
    if ({l_hit, l_old} !== {1'b0, 8'h00}) begin errors++;
      $display("FAIL other_idx got %b/%h want 0/00", l_hit, l_old); end
  endtask

  task automatic test_inv_priority;
    inv_valid = 1'b1; inv_idx = 6'd5;
    req_valid = 1'b1; req_idx = 6'd5; req_tag = 7'h13; req_alloc = 1'b0;
    #1;
    checks++;
    if ({req_ready, inv_ready} !== 2'b01) begin errors++;
      $display("FAIL inv_prio got %b want 01", {req_ready, inv_ready}); end
    @(negedge clk);
    inv_valid = 1'b0; req_valid = 1'b0;
    checks++;
    if ({ram_wr_en, ram_wr_addr, ram_wr_data} !== {1'b1, 6'd5, 8'h00})
      begin errors++; $display("FAIL inv_write got %b @%0d %h want 1 @5 00",
        ram_wr_en, ram_wr_addr, ram_wr_data); end
    lookup(6'd5, 7'h13, 1'b0);
    checks++;
    if ({l_hit, l_old} !== {1'b0, 8'h00} || l_lat != 3) begin errors++;
      $display("FAIL after_inv got %b/%h lat %0d want 0/00 lat 3",
        l_hit, l_old, l_lat); end
  endtask

  task automatic test_reset_mid;
    int bad, bad_rdy, bad_rsp;
    req_valid = 1'b1; req_idx = 6'd9; req_tag = 7'h01; req_alloc = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, ram_wr_en, init_done, req_ready} !== 4'b0) begin
      errors++; $display("FAIL mid_rst got %b want 0000",
        {rsp_valid, ram_wr_en, init_done, req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep_check(bad, bad_rdy, bad_rsp);
    checks++;
    if (bad != 0 || bad_rdy != 0) begin errors++;
      $display("FAIL resweep bad got %0d/%0d want 0/0", bad, bad_rdy); end
    checks++;
    if (bad_rsp != 0) begin errors++;
      $display("FAIL dropped_rsp got %0d want 0", bad_rsp); end
    @(negedge clk);
    checks++;
    if ({init_done, req_ready} !== 2'b11) begin errors++;
      $display("FAIL reinit got %b want 11", {init_done, req_ready}); end
  endtask

  task automatic test_stats;
    int h;
    h = 0;
    lookup(6'd9, 7'h01, 1'b1);
    if (l_hit === 1'b1) h++;
    for (int i = 0; i < 3; i++) begin
      lookup(6'd9, 7'h01, 1'b0);
      if (l_hit === 1'b1) h++;
    end
    lookup(6'd10, 7'h02, 1'b0);
    if (l_hit === 1'b1) h++;
    checks++;
    if (h != 3) begin errors++;
      $display("FAIL stats_hits_seen got %0d want 3", h); end
    @(negedge clk);
`ifdef TAG_LOOKUP_CTRL_STATS_EN
    checks++;
    if ({hit_cnt, miss_cnt} !== {16'd3, 16'd2}) begin errors++;
      $display("FAIL counters got %0d/%0d want 3/2", hit_cnt, miss_cnt); end
`else
    checks++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin errors++;
      $display("FAIL counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_miss_no_alloc();
    test_alloc_then_hit();
    test_replace();
    test_inv_priority();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
